mii_frame_transmitter: RTL and testbench
========================================

# mii_frame_transmitter

Serializes one Ethernet frame at a time onto the 4-bit MII transmit interface of the 10/100 PHY. Sits directly downstream of `ethernet_udp_transmit`, which supplies destination MAC through UDP payload as a byte stream. The block adds the preamble and SFD, pads short frames, appends the CRC-32 FCS, and enforces the inter-frame gap. It runs on the system clock and paces its output from PHY `tx_clk` edges.

## Interface
- `MIN_FRAME`, 60: minimum frame length in bytes before FCS; shorter frames are zero-padded up to this length.
- `IFG_NIBBLES`, 24: number of `tx_clk` ticks with `tx_en`=0 after each frame (96 bit times).
- `clk` in 1: system clock; frequency must be ≥ 4× `tx_clk`.
- `reset` in 1: synchronous, active-low reset.
- `s_data` in 8: frame byte.
- `s_valid` in 1: `s_data`/`s_last` are valid.
- `s_last` in 1: the current byte is the final byte of the frame.
- `s_ready` out 1: block accepts the byte; a transfer occurs when `s_valid && s_ready` at a `clk` edge.
- `tx_clk` in 1: PHY transmit clock, sampled as data.
- `tx_en` out 1: MII transmit enable.
- `tx_d` out 4: MII transmit nibble.
- `busy` out 1: high in every state except IDLE.
- `underrun` out 1: one-cycle pulse when a frame is aborted.
- `frame_done` out 1: one-cycle pulse on the last FCS nibble tick.

## Operation
- `tx_clk` passes through a 2-flop synchronizer. A rising-edge detect produces `tick` for one `clk` cycle. `tx_en` and `tx_d` change only on the cycle after `tick`.
- A one-byte holding register (`hold`, `hold_last`, `hold_valid`) buffers the input. `s_ready` = !`hold_valid` && state ∈ {IDLE, PREAMBLE, SFD, DATA, DRAIN} && no `s_last` has been accepted yet in the current frame.
- **IDLE**: `tx_en`=0 and `tx_d`=0. On the first `tick` with `hold_valid`=1, go to PREAMBLE.
- **PREAMBLE**: emit 0x5 for 15 ticks, including the entry tick.
- **SFD**: emit 0xD for 1 tick.
- **DATA**: each byte takes two ticks, low nibble first.
  - On the low-nibble tick: move `hold` into the shift register, clear `hold_valid`, and feed the byte to the CRC. Increment `byte_cnt` (11 bits, saturates at 2047).
  - On the high-nibble tick of a `hold_last` byte: go to PAD if `byte_cnt` < `MIN_FRAME`, else go to FCS.
  - Underrun: if a low-nibble tick arrives with `hold_valid`=0 and the last byte has not yet been sent, drive `tx_en`=0 and `tx_d`=0 that tick, pulse `underrun`, and go to DRAIN.
- **PAD**: emit 0x0 nibbles. The CRC is fed 0x00 per byte. Go to FCS when `byte_cnt` = `MIN_FRAME`.
- **FCS**: emit ~`crc` over 8 ticks, least-significant nibble first. Pulse `frame_done` on the 8th tick, then go to IFG.
- **DRAIN**: `tx_en`=0. Accept and discard bytes until `s_last` is accepted, then go to IFG.
- **IFG**: `tx_en`=0 for `IFG_NIBBLES` ticks, then go to IDLE.
- **CRC-32**: reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at PREAMBLE entry. Covers data bytes and pad bytes; preamble and SFD are excluded.

## Timing
- Reset values: `tx_en`=0, `tx_d`=0, `s_ready`=0, `busy`=0, `underrun`=0, `frame_done`=0. The state is IDLE, `hold_valid`=0, `byte_cnt`=0, and the CRC is 0xFFFFFFFF.
- `s_ready` rises on the first cycle after reset is released.
- Reset asserted mid-frame: `tx_en` is 0 on the next `clk` edge. No FCS or IFG is emitted, and the partial frame is lost.
- Latency from a byte transfer to `tx_en` rising is the first following `tick` plus 1 `clk`.
- `tx_en` stays high for 16 + 2·max(N, `MIN_FRAME`) + 8 consecutive ticks for an N-byte frame.
- Simultaneous `tick` and input transfer in the same cycle: the tick logic samples `hold_valid` before the transfer, so the byte counts for the next tick.
- `s_valid` with `s_ready`=0: the byte is held by the upstream block and not lost. No combinational path exists from `s_valid` to `s_ready`.

## Test plan
- **Short frame**: 1-byte frame 0xAB. Required on the wire: 15×0x5, 0xD, 0xB, 0xA, 118×0x0, then 8 FCS nibbles. `tx_en` is high for exactly 144 ticks, followed by 24 idle ticks.
- **Exact minimum length**: 64-byte frame 0x00..0x3F. No pad; `tx_en` is high for 152 ticks. Running the CRC over the 64 data bytes plus the 4 FCS bytes gives residue 0xDEBB20E3, and the FCS matches a software CRC-32 model.
- **Back-to-back frames**: two 60-byte frames offered continuously. The gap between them is exactly 24 ticks with `tx_en`=0, and `frame_done` pulses twice.
- **Underrun**: withhold `s_valid` after byte 10 for 3 ticks, then send the remaining 5 bytes with `s_last`. Required: `underrun` pulses once, `tx_en` falls on the underrun tick, the 5 bytes are discarded, there is no `frame_done`, and the next frame starts with a clean preamble.
- **Reset mid-FCS**: assert `reset` during FCS nibble 3. Required: all outputs return to their reset values on the next `clk` edge, and the following frame emits a correct FCS.
- **Clock ratio**: `clk` set to exactly 4× `tx_clk`, 100-byte frame. No nibble is skipped or duplicated, and `s_ready` never blocks a byte past its low-nibble tick.

Source files
------------

// File: rtl/mii_frame_transmitter_if.sv
// rtl/mii_frame_transmitter_if.sv - byte stream handshake into the MII frame transmitter
interface mii_frame_transmitter_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/mii_frame_transmitter.sv
// rtl/mii_frame_transmitter.sv - Ethernet frame serializer onto the 4-bit MII transmit path
// Adds preamble/SFD, pads to the minimum length, appends CRC-32 FCS and holds the inter-frame gap.
module mii_frame_transmitter #(
  parameter int MIN_FRAME   = 60,
  parameter int IFG_NIBBLES = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  mii_frame_transmitter_if.slave        s,
  input  logic                          tx_clk,
  output logic                          tx_en,
  output logic [3:0]                    tx_d,
  output logic                          busy,
  output logic                          underrun,
  output logic                          frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_DRAIN, ST_IFG
  } state_t;

  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_NIBBLES - 1);

  state_t      state_q;
  logic [2:0]  sync_q;
  logic        run_q;
  logic [7:0]  hold_q;
  logic        hold_last_q;
  logic        hold_valid_q;
  logic        last_acc_q;
  logic [7:0]  shift_q;
  logic        shift_last_q;
  logic        phase_q;
  logic [7:0]  cnt_q;
  logic [10:0] byte_cnt_q;
  logic [31:0] crc_q;

  logic        tick;
  logic        accept_state;
  logic        xfer;
  logic [7:0]  crc_in;
  logic [31:0] crc_d;
  logic [31:0] fcs;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // sync_q[1] is the synchronized tx_clk, sync_q[2] its previous value
  assign tick         = sync_q[1] & ~sync_q[2];
  assign accept_state = state_q inside {ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA, ST_DRAIN};
  assign s.s_ready    = run_q & ~hold_valid_q & ~last_acc_q & accept_state;
  assign xfer         = s.s_valid & s.s_ready;
  assign crc_in       = (state_q == ST_DATA) ? hold_q : 8'h00;
  assign crc_d        = crc32_byte(crc_q, crc_in);
  assign fcs          = ~crc_q;
  assign busy         = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sync_q       <= 3'b000;
      run_q        <= 1'b0;
      hold_q       <= 8'h00;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      last_acc_q   <= 1'b0;
      shift_q      <= 8'h00;
      shift_last_q <= 1'b0;
      phase_q      <= 1'b0;
      cnt_q        <= 8'd0;
      byte_cnt_q   <= 11'd0;
      crc_q        <= 32'hFFFFFFFF;
      tx_en        <= 1'b0;
      tx_d         <= 4'h0;
      underrun     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], tx_clk};
      run_q      <= 1'b1;
      underrun   <= 1'b0;
      frame_done <= 1'b0;

      // Bytes accepted while draining an aborted frame are dropped on the floor
      if (xfer && state_q != ST_DRAIN) begin
        hold_q       <= s.s_data;
        hold_last_q  <= s.s_last;
        hold_valid_q <= 1'b1;
      end
      if (xfer && s.s_last) begin
        last_acc_q <= 1'b1;
      end
      if (xfer && s.s_last && state_q == ST_DRAIN) begin
        state_q <= ST_IFG;
        cnt_q   <= 8'd0;
      end

      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            if (hold_valid_q) begin
              tx_en      <= 1'b1;
              tx_d       <= 4'h5;
              cnt_q      <= 8'd1;
              byte_cnt_q <= 11'd0;
              crc_q      <= 32'hFFFFFFFF;
              state_q    <= ST_PREAMBLE;
            end
          end
          ST_PREAMBLE: begin
            tx_d  <= 4'h5;
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'd14) state_q <= ST_SFD;
          end
          ST_SFD: begin
            tx_d    <= 4'hD;
            phase_q <= 1'b0;
            state_q <= ST_DATA;
          end
          ST_DATA: begin
            if (!phase_q) begin
              if (hold_valid_q) begin
                tx_d         <= hold_q[3:0];
                shift_q      <= hold_q;
                shift_last_q <= hold_last_q;
                hold_valid_q <= 1'b0;
                crc_q        <= crc_d;
                if (byte_cnt_q != 11'h7FF) byte_cnt_q <= byte_cnt_q + 11'd1;
                phase_q      <= 1'b1;
              end else begin
                tx_en    <= 1'b0;
                tx_d     <= 4'h0;
                underrun <= 1'b1;
                state_q  <= ST_DRAIN;
              end
            end else begin
              tx_d    <= shift_q[7:4];
              phase_q <= 1'b0;
              if (shift_last_q) begin
                state_q <= (byte_cnt_q < MIN_CNT) ? ST_PAD : ST_FCS;
                cnt_q   <= 8'd0;
              end
            end
          end
          ST_PAD: begin
            tx_d    <= 4'h0;
            phase_q <= ~phase_q;
            if (!phase_q) begin
              crc_q      <= crc_d;
              byte_cnt_q <= byte_cnt_q + 11'd1;
            end else if (byte_cnt_q == MIN_CNT) begin
              state_q <= ST_FCS;
              cnt_q   <= 8'd0;
            end
          end
          ST_FCS: begin
            tx_d  <= fcs[{cnt_q[2:0], 2'b00} +: 4];
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              frame_done <= 1'b1;
              state_q    <= ST_IFG;
              cnt_q      <= 8'd0;
            end
          end
          ST_DRAIN: begin
          end
          ST_IFG: begin
            tx_en <= 1'b0;
            tx_d  <= 4'h0;
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == IFG_LAST) begin
              state_q    <= ST_IDLE;
              cnt_q      <= 8'd0;
              last_acc_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mii_frame_transmitter.sv
// tb/tb_mii_frame_transmitter.sv - directed self-checking bench for mii_frame_transmitter
module tb_mii_frame_transmitter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_clk = 1'b0;
  logic       tx_en;
  logic [3:0] tx_d;
  logic       busy;
  logic       underrun;
  logic       frame_done;

  mii_frame_transmitter_if sif ();

  mii_frame_transmitter #(.MIN_FRAME(60), .IFG_NIBBLES(24)) dut (
    .clk(clk), .reset(reset), .s(sif), .tx_clk(tx_clk), .tx_en(tx_en),
    .tx_d(tx_d), .busy(busy), .underrun(underrun), .frame_done(frame_done)
  );

  // clk is exactly 4x tx_clk; tx_clk edges sit 2 ns after a clk rising edge
  always #5 clk = ~clk;
  initial begin
    #7;
    forever begin
      tx_clk = 1'b1; #20;
      tx_clk = 1'b0; #20;
    end
  end

  logic       en_log[$];
  logic [3:0] d_log[$];
  int         ones_total = 0;
  int         n_done = 0;
  int         n_under = 0;

  always @(posedge tx_clk) begin
    en_log.push_back(tx_en);
    d_log.push_back(tx_d);
    if (tx_en) ones_total++;
  end

  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (underrun) n_under++;
  end

  int n_tests = 0;
  int n_fail = 0;
  int stalls = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  logic [7:0] frame_q[$];
  int         run_st[$];
  int         run_ln[$];

  task automatic send_byte(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    sif.s_data  = d;
    sif.s_valid = 1'b1;
    sif.s_last  = last;
    while (!sif.s_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) stalls++;
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], i == frame_q.size() - 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!busy) stalls++;
    t = 0;
    while (busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (busy) stalls++;
    repeat (8) @(negedge clk);
  endtask

  task automatic find_runs(input int base);
    int i;
    int s;
    run_st.delete();
    run_ln.delete();
    i = base;
    while (i < en_log.size()) begin
      if (en_log[i]) begin
        s = i;
        while (i < en_log.size() && en_log[i]) i++;
        run_st.push_back(s);
        run_ln.push_back(i - s);
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int r);
    logic [3:0]  exp_n[$];
    logic [31:0] crc;
    logic [7:0]  b;
    int          padded;
    int          bad;
    padded = (frame_q.size() < 60) ? 60 : frame_q.size();
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 15; i++) exp_n.push_back(4'h5);
    exp_n.push_back(4'hD);
    for (int i = 0; i < padded; i++) begin
      b = (i < frame_q.size()) ? frame_q[i] : 8'h00;
      crc = ref_crc(crc, b);
      exp_n.push_back(b[3:0]);
      exp_n.push_back(b[7:4]);
    end
    crc = ~crc;
    for (int i = 0; i < 8; i++) exp_n.push_back(crc[4*i +: 4]);
    if (r >= run_st.size()) begin
      check({tag, "_present"}, run_st.size(), r + 1);
      return;
    end
    check({tag, "_len"}, run_ln[r], exp_n.size());
    bad = 0;
    for (int i = 0; i < exp_n.size(); i++) begin
      if (i >= run_ln[r] || d_log[run_st[r] + i] !== exp_n[i]) bad++;
    end
    check({tag, "_nibbles"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  int          base;
  int          d0;
  int          u0;
  int          ones0;
  int          bad;
  int          t;
  logic [31:0] crc;
  logic [7:0]  b;

  initial begin
    sif.s_data  = 8'h00;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_d", tx_d, 0);
    check("rst_s_ready", sif.s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", sif.s_ready, 1);

    // 1-byte frame: 15x5, D, B, A, 118 pad nibbles, FCS -> 144 ticks
    base = en_log.size(); d0 = n_done;
    frame_q = '{8'hAB};
    send_frame();
    wait_done();
    find_runs(base);
    check("short_runs", run_st.size(), 1);
    check_frame("short", 0);
    check("short_done", n_done - d0, 1);

    // exactly 64 bytes: no pad, 152 ticks, CRC residue over data+FCS
    base = en_log.size();
    frame_q.delete();
    for (int i = 0; i < 64; i++) frame_q.push_back(8'(i));
    send_frame();
    wait_done();
    find_runs(base);
    check_frame("min64", 0);
    if (run_st.size() > 0 && run_ln[0] >= 152) begin
      crc = 32'hFFFFFFFF;
      for (int k = 0; k < 68; k++) begin
        b = {d_log[run_st[0] + 16 + 2*k + 1], d_log[run_st[0] + 16 + 2*k]};
        crc = ref_crc(crc, b);
      end
      check("min64_residue", crc, 32'hDEBB20E3);
    end

    // back-to-back 60-byte frames
    base = en_log.size(); d0 = n_done;
    frame_q.delete();
    for (int i = 0; i < 60; i++) frame_q.push_back(8'(i * 3 + 1));
    send_frame();
    send_frame();
    wait_done();
    find_runs(base);
    check("b2b_runs", run_st.size(), 2);
    check_frame("b2b_first", 0);
    check_frame("b2b_second", 1);
    if (run_st.size() >= 2) check("b2b_gap", run_st[1] - (run_st[0] + run_ln[0]), 24);
    check("b2b_done", n_done - d0, 2);

    // underrun after byte 10, then 5 trailing bytes discarded
    base = en_log.size(); d0 = n_done; u0 = n_under;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i), 1'b0);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hE0 + i), i == 4);
    wait_done();
    find_runs(base);
    check("urun_pulses", n_under - u0, 1);
    check("urun_no_done", n_done - d0, 0);
    check("urun_runs", run_st.size(), 1);
    if (run_st.size() > 0) begin
      check("urun_len", run_ln[0], 36);
      bad = 0;
      for (int i = 0; i < 36 && i < run_ln[0]; i++) begin
        b = 8'(8'h10 + (i - 16) / 2);
        if (i < 15 && d_log[run_st[0] + i] !== 4'h5) bad++;
        if (i == 15 && d_log[run_st[0] + i] !== 4'hD) bad++;
        if (i >= 16 && d_log[run_st[0] + i] !== ((i % 2 == 0) ? b[3:0] : b[7:4])) bad++;
      end
      check("urun_prefix", bad, 0);
    end
    base = en_log.size();
    frame_q = '{8'h5A, 8'hC3};
    send_frame();
    wait_done();
    find_runs(base);
    check_frame("after_urun", 0);

    // reset asserted while FCS nibble 3 is on the wire
    base = en_log.size(); ones0 = ones_total;
    frame_q = '{8'h3C};
    send_frame();
    t = 0;
    while (ones_total - ones0 < 138 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) stalls++;
    repeat (4) @(negedge clk);
    crc = 32'hFFFFFFFF;
    crc = ref_crc(crc, 8'h3C);
    for (int i = 1; i < 60; i++) crc = ref_crc(crc, 8'h00);
    crc = ~crc;
    check("rstfcs_pre_en", tx_en, 1);
    check("rstfcs_pre_nibble3", tx_d, crc[11:8]);
    d0 = n_done;
    reset = 1'b0;
    @(negedge clk);
    check("rstfcs_tx_en", tx_en, 0);
    check("rstfcs_tx_d", tx_d, 0);
    check("rstfcs_busy", busy, 0);
    check("rstfcs_s_ready", sif.s_ready, 0);
    check("rstfcs_frame_done", frame_done, 0);
    check("rstfcs_underrun", underrun, 0);
    reset = 1'b1;
    ones0 = ones_total;
    repeat (200) @(negedge clk);
    check("rstfcs_no_tail", ones_total - ones0, 0);
    check("rstfcs_no_done", n_done - d0, 0);
    base = en_log.size();
    frame_q = '{8'hE7, 8'h18, 8'h99};
    send_frame();
    wait_done();
    find_runs(base);
    check_frame("post_rst", 0);

    // 100-byte frame at the minimum clock ratio
    base = en_log.size(); u0 = n_under; d0 = n_done;
    frame_q.delete();
    for (int i = 0; i < 100; i++) frame_q.push_back(8'(i * 7 + 3));
    send_frame();
    wait_done();
    find_runs(base);
    check_frame("ratio100", 0);
    check("ratio100_no_urun", n_under - u0, 0);
    check("ratio100_done", n_done - d0, 1);

    check("handshake_stalls", stalls, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
